// File: rtl/multi_queue_issue_pkg.sv
// ============================================================================
// Module : multi_queue_issue_pkg
// Brief  : Shared types for the multi-queue issue stage (watchdog states, credits).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package multi_queue_issue_pkg;

  localparam int DEFAULT_DEPTH = 8;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_STALLED = 1'b1
  } wd_state_e;

  typedef logic [$clog2(DEFAULT_DEPTH+1)-1:0] credit_t;

endpackage

`default_nettype wire

// File: rtl/multi_queue_issue_credit_counter.sv
// ============================================================================
// Module : multi_queue_issue_credit_counter
// Brief  : Per-queue credit counter; saturates at DEPTH and flags overflow.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multi_queue_issue_credit_counter
  import multi_queue_issue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             dec_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o,
  output logic             zero_o,
  output logic             overflow_o
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d    = count_q;
    overflow_o = 1'b0;
    case ({dec_i, inc_i})
      2'b10: count_d = count_q - CNT_W'(1);
      2'b01: begin
        // A return into an already-full queue is a protocol error; hold at full.
        if (count_q == FULL) overflow_o = 1'b1;
        else                 count_d    = count_q + CNT_W'(1);
      end
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) count_q <= FULL;
    else          count_q <= count_d;
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/multi_queue_issue.sv
// ============================================================================
// Module : multi_queue_issue
// Brief  : All-or-nothing issue of decoded ops to NUM_Q credited queues with replay and stall watchdog.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multi_queue_issue
  import multi_queue_issue_pkg::*;
#(
  parameter int NUM_Q       = 4,
  parameter int DEPTH       = 8,
  parameter int DATA_W      = 32,
  parameter int STALL_LIMIT = 16,
  parameter int CNT_W       = $clog2(DEPTH+1)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   in_valid_i,
  input  logic [NUM_Q-1:0]       in_enq_mask_i,
  input  logic [DATA_W-1:0]      in_bits_i,
  output logic                   in_ready_o,
  output logic                   replay_o,
  input  logic                   flush_i,
  output logic [NUM_Q-1:0]       out_valid_o,
  output logic [DATA_W-1:0]      out_bits_o,
  input  logic [NUM_Q-1:0]       credit_ret_i,
  output logic [NUM_Q*CNT_W-1:0] credits_o,
  output logic                   stall_timeout_o,
  output logic                   err_overflow_o
);

  localparam int               STALL_W   = $clog2(STALL_LIMIT+1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT-1);

  logic [NUM_Q-1:0] zero, need, dec, ovf;
  logic             fire;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_Q; gi++) begin : g_credit
      logic [CNT_W-1:0] count;
      multi_queue_issue_credit_counter #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .dec_i      (dec[gi]),
        .inc_i      (credit_ret_i[gi]),
        .count_o    (count),
        .zero_o     (zero[gi]),
        .overflow_o (ovf[gi])
      );
      assign credits_o[gi*CNT_W +: CNT_W] = count;
    end
  endgenerate

  assign need       = in_enq_mask_i & zero;
  assign in_ready_o = reset_i && !flush_i && !(|need);
  assign fire       = in_valid_i && in_ready_o;
  assign replay_o   = in_valid_i && !in_ready_o;
  assign dec        = {NUM_Q{fire}} & in_enq_mask_i;

  logic [NUM_Q-1:0]  out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_bits_q, out_bits_d;
  logic              err_q, err_d;

  always_comb begin
    out_valid_d = fire ? in_enq_mask_i : '0;
    out_bits_d  = fire ? in_bits_i : out_bits_q;
    err_d       = err_q | (|ovf);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      out_valid_q <= '0;
      out_bits_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_bits_q  <= out_bits_d;
      err_q       <= err_d;
    end
  end

  assign out_valid_o    = out_valid_q;
  assign out_bits_o     = out_bits_q;
  assign err_overflow_o = err_q;

  wd_state_e        state_q, state_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    if (flush_i || !replay_o)         stall_cnt_d = '0;
    else if (stall_cnt_q != STALL_MAX) stall_cnt_d = stall_cnt_q + STALL_W'(1);
    case (state_q)
      ST_RUN:     if (replay_o && !flush_i && stall_cnt_q == STALL_MAX) state_d = ST_STALLED;
      ST_STALLED: if (fire || flush_i) state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  assign stall_timeout_o = (state_q == ST_STALLED);

endmodule

`default_nettype wire

// File: tb/tb_multi_queue_issue.sv
// ============================================================================
// Module : tb_multi_queue_issue
// Brief  : Directed and random stimulus against a cycle-level credit/issue reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multi_queue_issue;

  localparam int NUM_Q = 4;
  localparam int DEPTH = 8;
  localparam int DW    = 32;
  localparam int LIMIT = 16;
  localparam int CW    = 4;

  logic              clk = 1'b0;
  logic              reset_n, valid, flush;
  logic [NUM_Q-1:0]  mask, ret;
  logic [DW-1:0]     bits;
  logic              in_ready, replay, stall_timeout, err_overflow;
  logic [NUM_Q-1:0]  out_valid;
  logic [DW-1:0]     out_bits;
  logic [NUM_Q*CW-1:0] credits;

  always #5 clk = ~clk;

  multi_queue_issue #(
    .NUM_Q(NUM_Q), .DEPTH(DEPTH), .DATA_W(DW), .STALL_LIMIT(LIMIT), .CNT_W(CW)
  ) dut (
    .clk_i(clk), .reset_i(reset_n), .in_valid_i(valid), .in_enq_mask_i(mask),
    .in_bits_i(bits), .in_ready_o(in_ready), .replay_o(replay), .flush_i(flush),
    .out_valid_o(out_valid), .out_bits_o(out_bits), .credit_ret_i(ret),
    .credits_o(credits), .stall_timeout_o(stall_timeout), .err_overflow_o(err_overflow)
  );

  int n_vec = 0;
  int n_err = 0;

  int               m_cred [NUM_Q];
  logic [NUM_Q-1:0] m_ov;
  logic [DW-1:0]    m_bits;
  bit               m_err, m_stalled;
  int               m_scnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_Q; i++) m_cred[i] = DEPTH;
    m_ov = '0; m_bits = '0; m_err = 0; m_stalled = 0; m_scnt = 0;
  endtask

  // One clock: compare everything at the falling edge, then advance the model.
  task automatic step();
    bit rdy, fire, rep, under;
    logic [NUM_Q*CW-1:0] ecred;
    int nc [NUM_Q];
    @(negedge clk);
    rdy = reset_n && !flush;
    for (int i = 0; i < NUM_Q; i++) if (mask[i] && m_cred[i] == 0) rdy = 0;
    fire = valid && rdy;
    rep  = valid && !rdy;
    for (int i = 0; i < NUM_Q; i++) ecred[i*CW +: CW] = CW'(m_cred[i]);
    chk("in_ready", in_ready, rdy);
    chk("replay", replay, rep);
    chk("out_valid", out_valid, m_ov);
    chk("out_bits", out_bits, m_bits);
    chk("credits", credits, ecred);
    chk("stall_timeout", stall_timeout, m_stalled);
    chk("err_overflow", err_overflow, m_err);
    under = 0;
    for (int i = 0; i < NUM_Q; i++) begin
      nc[i] = m_cred[i] - ((fire && mask[i]) ? 1 : 0) + (ret[i] ? 1 : 0);
      if (nc[i] < 0) under = 1;
    end
    chk("no_underflow", under, 0);
    @(posedge clk);
    #1;
    if (!reset_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < NUM_Q; i++) begin
        if (nc[i] > DEPTH) begin
          nc[i] = DEPTH;
          m_err = 1;
        end
        m_cred[i] = nc[i];
      end
      m_ov = fire ? mask : '0;
      if (fire) m_bits = bits;
      if (m_stalled) begin
        if (fire || flush) m_stalled = 0;
      end else if (rep && !flush && m_scnt == LIMIT-1) begin
        m_stalled = 1;
      end
      if (flush || !rep) m_scnt = 0;
      else if (m_scnt < LIMIT-1) m_scnt++;
    end
  endtask

  initial begin
    reset_n = 0; valid = 0; flush = 0; mask = '0; ret = '0; bits = '0;
    @(posedge clk);
    #1;
    model_reset();
    step();
    reset_n = 1;

    // Fill queues 0 and 1.
    valid = 1; mask = 4'b0011;
    for (int k = 0; k < 8; k++) begin
      bits = $urandom;
      step();
    end
    chk("fill_c0", credits[3:0], 0);
    chk("fill_c1", credits[7:4], 0);
    chk("fill_c2", credits[11:8], 8);
    #2;
    chk("ninth_ready", in_ready, 0);
    chk("ninth_replay", replay, 1);
    step();

    // Watchdog: 16 consecutive replays with queue 0 empty.
    valid = 0; step();
    valid = 1; mask = 4'b0101; bits = 32'hCAFE_0101;
    repeat (15) step();
    chk("stall_pre", stall_timeout, 0);
    step();
    chk("stall_rise", stall_timeout, 1);
    ret = 4'b0001; step();
    ret = 4'b0000; step();
    valid = 0;
    chk("retry_ov", out_valid, 4'b0101);
    chk("retry_bits", out_bits, 32'hCAFE_0101);
    chk("retry_c0", credits[3:0], 0);
    chk("retry_c2", credits[11:8], 7);
    chk("stall_fall", stall_timeout, 0);
    step();

    // Simultaneous fire and return on queue 1.
    ret = 4'b0010; repeat (3) step();
    ret = 4'b0000;
    chk("c1_three", credits[7:4], 3);
    valid = 1; mask = 4'b0010; ret = 4'b0010; bits = $urandom; step();
    valid = 0; ret = 4'b0000;
    chk("c1_hold", credits[7:4], 3);
    chk("c1_ov", out_valid, 4'b0010);
    step();

    // Fire then flush.
    valid = 1; mask = 4'b0100; bits = 32'h0000_F1F1; step();
    flush = 1;
    #2;
    chk("flush_ready", in_ready, 0);
    chk("flush_ov", out_valid, 4'b0100);
    step();
    flush = 0; valid = 0;
    chk("postflush_ov", out_valid, 0);
    chk("postflush_c2", credits[11:8], 6);
    step();

    // Overflow on queue 3, then reset mid-stream.
    ret = 4'b1000; step();
    ret = 4'b0000; repeat (3) step();
    chk("ovf_err", err_overflow, 1);
    chk("ovf_c3", credits[15:12], 8);
    reset_n = 0; valid = 1; mask = 4'b1111; step();
    reset_n = 1; valid = 0;
    chk("rst_credits", credits, 16'h8888);
    chk("rst_err", err_overflow, 0);
    chk("rst_ov", out_valid, 0);
    step();

    // Random traffic.
    for (int k = 0; k < 1500; k++) begin
      valid   = ($urandom_range(0, 3) != 0);
      mask    = 4'($urandom_range(0, 15));
      bits    = $urandom;
      ret     = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      flush   = ($urandom_range(0, 15) == 0);
      reset_n = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
